// File: rtl/trit_packer_if.sv
// Coefficient-in / byte-out handshake bundle for the trit packer.
// The packer takes the slave side; the producer/consumer side takes master.
interface trit_packer_if;
    logic        in_valid;
    logic [12:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );
endinterface

// File: rtl/trit_packer.sv
// Packs a stream of mod-3 coefficients four per byte (2-bit little-endian fields)
// into the Small-polynomial byte encoding, one polynomial per start pulse.
module trit_packer #(
    parameter int unsigned P      = 757,
    parameter int unsigned NBYTES = 190
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    trit_packer_if.slave   bus,
    output logic           busy,
    output logic           done,
    output logic           err
);

    typedef enum logic [1:0] {StIdle, StRun, StOut, StDone} state_e;

    localparam logic [9:0] CoefLast = 10'(P - 1);
    localparam logic [7:0] ByteLast = 8'(NBYTES - 1);

    state_e     state_q, state_d;
    logic [9:0] coef_cnt_q, coef_cnt_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [1:0] field_q, field_d;
    logic [7:0] shreg_q, shreg_d;
    logic       err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            coef_cnt_q <= '0;
            byte_cnt_q <= '0;
            field_q    <= '0;
            shreg_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            coef_cnt_q <= coef_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            field_q    <= field_d;
            shreg_q    <= shreg_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        coef_cnt_d = coef_cnt_q;
        byte_cnt_d = byte_cnt_q;
        field_d    = field_q;
        shreg_d    = shreg_q;
        err_d      = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRun;
                    coef_cnt_d = '0;
                    byte_cnt_d = '0;
                    field_d    = '0;
                    shreg_d    = '0;
                    err_d      = 1'b0;
                end
            end
            StRun: begin
                if (bus.in_valid) begin
                    // Illegal values still land in the field; only the flag records them.
                    shreg_d[{field_q, 1'b0} +: 2] = bus.in_data[1:0];
                    if (bus.in_data > 13'd2) begin
                        err_d = 1'b1;
                    end
                    coef_cnt_d = coef_cnt_q + 10'd1;
                    if (field_q == 2'd3 || coef_cnt_q == CoefLast) begin
                        state_d = StOut;
                    end else begin
                        field_d = field_q + 2'd1;
                    end
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    if (byte_cnt_q == ByteLast) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StRun;
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        field_d    = '0;
                        shreg_d    = '0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == StRun);
    assign bus.out_valid = (state_q == StOut);
    assign bus.out_data  = shreg_q;
    assign bus.out_last  = (state_q == StOut) && (byte_cnt_q == ByteLast);
    assign busy          = (state_q == StRun) || (state_q == StOut);
    assign done          = (state_q == StDone);
    assign err           = err_q;

endmodule
